spi_master_tx: RTL

- Transmit datapath of the SPI master. It sits directly downstream of the SCK clock generator, which is driven by this block's clk_en_o and whose falling-edge strobe arrives here as tx_edge.
- Accepts 32-bit words from the TX FIFO over a valid/ready handshake and serialises a programmable number of bits, MSB first, onto sdo in standard (1-bit) or quad (4-bit) mode.
- Gates the clock generator and pulses tx_done when the transfer completes.

---
 rtl/spi_master_pkg.sv | 16 +
 rtl/spi_master_clkgen.sv | 34 +++
 rtl/spi_master_tx.sv | 106 ++++++++++
 3 files changed

// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI master blocks.
package spi_master_pkg;

  localparam int SPI_WORD_W = 32;
  localparam int SPI_CNT_W  = 16;

  localparam logic SPI_STD  = 1'b0;
  localparam logic SPI_QUAD = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRANSMIT = 2'd1,
    DONE     = 2'd2
  } tx_state_e;

endpackage

// File: rtl/spi_master_clkgen.sv
// SCK generator: toggles sck every clk_div enabled cycles, strobing spi_rise/spi_fall.
module spi_master_clkgen (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] clk_div,
  output logic       sck,
  output logic       spi_rise,
  output logic       spi_fall
);

  logic [7:0] cnt;
  logic       tick;

  // Strobes are gated by en combinationally so a stall suppresses them immediately.
  assign tick     = en && (cnt == clk_div - 8'd1);
  assign spi_rise = tick && !sck;
  assign spi_fall = tick && sck;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_master_tx.sv
// SPI master transmit datapath: takes FIFO words and shifts them out MSB first
// on sdo in standard (1-bit) or quad (4-bit) mode, one step per tx_edge.
module spi_master_tx
  import spi_master_pkg::*;
#(
  parameter int WORD_W = SPI_WORD_W,
  parameter int CNT_W  = SPI_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              en_quad,
  input  logic [CNT_W-1:0]  counter_in,
  input  logic              tx_edge,
  input  logic [WORD_W-1:0] data,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              clk_en_o,
  output logic              tx_done,
  output logic [3:0]        sdo
);

  localparam int WEC_W = $clog2(WORD_W) + 1;
  localparam logic [WEC_W-1:0] E_STD  = WEC_W'(WORD_W);
  localparam logic [WEC_W-1:0] E_QUAD = WEC_W'(WORD_W / 4);

  // Handshake: a word moves from the FIFO in any cycle where data_valid and
  // data_ready are both high; data_ready never depends on data_valid.
  tx_state_e         state, state_next;
  logic              quad;
  logic [CNT_W-1:0]  n_target, n_start, edge_cnt;
  logic [WEC_W-1:0]  word_edge_cnt, wec_base, wec_inc, edges_per_word;
  logic [WORD_W-1:0] shift_reg, src, src_shifted;
  logic              word_empty, edges_left, accept, launch;

  assign n_start        = (en_quad == SPI_QUAD) ? (counter_in >> 2) : counter_in;
  assign edges_left     = edge_cnt < n_target;
  assign accept         = data_valid && data_ready;
  assign launch         = (state == TRANSMIT) && tx_edge && edges_left && (!word_empty || data_valid);
  assign src            = word_empty ? data : shift_reg;
  assign src_shifted    = quad ? (src << 4) : (src << 1);
  assign edges_per_word = quad ? E_QUAD : E_STD;
  assign wec_base       = accept ? '0 : word_edge_cnt;
  assign wec_inc        = wec_base + WEC_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    data_ready = 1'b0;
    clk_en_o   = 1'b0;
    tx_done    = 1'b0;
    case (state)
      IDLE: begin
        if (en) state_next = (n_start == '0) ? DONE : TRANSMIT;
      end
      TRANSMIT: begin
        data_ready = word_empty && edges_left;
        clk_en_o   = !(word_empty && !data_valid && edges_left);
        // The edge after the last launch closes the final bit's full period.
        if (tx_edge && !edges_left) state_next = DONE;
      end
      DONE: begin
        tx_done    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quad          <= 1'b0;
      n_target      <= '0;
      edge_cnt      <= '0;
      word_edge_cnt <= '0;
      shift_reg     <= '0;
      word_empty    <= 1'b1;
      sdo           <= 4'b0;
    end else begin
      if (state == IDLE && en && n_start != '0) begin
        n_target      <= n_start;
        quad          <= en_quad;
        edge_cnt      <= '0;
        word_edge_cnt <= '0;
        word_empty    <= 1'b1;
      end
      if (accept) begin
        shift_reg     <= data;
        word_empty    <= 1'b0;
        word_edge_cnt <= '0;
      end
      if (launch) begin
        sdo           <= quad ? src[WORD_W-1 -: 4] : {3'b000, src[WORD_W-1]};
        shift_reg     <= src_shifted;
        edge_cnt      <= edge_cnt + CNT_W'(1);
        word_edge_cnt <= wec_inc;
        word_empty    <= (wec_inc == edges_per_word);
      end
    end
  end

endmodule
